r_rom_backend: RTL and testbench

- Far-side command processor for the r_rom link; sits downstream of the command FIFO and upstream of the response FIFO.
- Pops 8-byte little-endian read commands from the command FIFO and performs one 64-bit ROM read per command.
- Pushes the 8-byte little-endian result into the response FIFO.
- Replaces the bench byte-loopback with a real memory lookup that has address checking.

---
 rtl/r_rom_backend.sv | 178 +++++++++++++++++
 tb/tb_r_rom_backend.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_rom_backend.sv
// Far-side command processor for the r_rom link: assembles 8-byte read commands,
// range-checks the address, performs one 64-bit ROM read and streams the result back.
module r_rom_backend #(
    parameter logic [63:0] ROM_BASE  = 64'h0000_0000_0000_1000,
    parameter logic [63:0] ROM_BYTES = 64'h0000_0000_0000_2000,
    parameter logic [63:0] ERR_DATA  = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        empty,
    output logic        rd_en,
    input  logic [7:0]  dout,
    input  logic        full,
    output logic        wr_en,
    output logic [7:0]  din,
    output logic        mem_req,
    output logic [60:0] mem_addr,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        busy,
    output logic        err,
    output logic [15:0] cmd_cnt
);

    typedef enum logic [1:0] {
        S_CMD = 2'd0,
        S_MEM = 2'd1,
        S_RSP = 2'd2
    } state_t;

    // Upper bound carried in 65 bits so that ROM_BASE+ROM_BYTES can never wrap.
    localparam logic [64:0] ROM_LIMIT = {1'b0, ROM_BASE} + {1'b0, ROM_BYTES};
    localparam logic [60:0] BASE_WORD = ROM_BASE[63:3];

    state_t      r_state;
    logic [63:0] r_buff;
    logic [3:0]  r_iss_cnt;
    logic [2:0]  r_cap_cnt;
    logic [2:0]  r_out_cnt;
    logic        r_rd_pend;
    logic        r_mem_req;
    logic [60:0] r_mem_addr;
    logic        r_err;
    logic [15:0] r_cmd_cnt;

    state_t      w_state_nxt;
    logic [63:0] w_buff_nxt;
    logic [3:0]  w_iss_nxt;
    logic [2:0]  w_cap_nxt;
    logic [2:0]  w_out_nxt;
    logic        w_mem_req_nxt;
    logic [60:0] w_mem_addr_nxt;
    logic        w_err_nxt;
    logic [15:0] w_cmd_cnt_nxt;
    logic        w_rd_en;
    logic        w_wr_en;
    logic [63:0] w_addr;

    function automatic logic addr_ok(input logic [63:0] a);
        logic [64:0] a_ext;
        a_ext = {1'b0, a};
        return (a[2:0] == 3'b000) && (a_ext >= {1'b0, ROM_BASE}) && (a_ext < ROM_LIMIT);
    endfunction

    assign w_addr = {dout, r_buff[63:8]};

    // Next-state and FIFO/ROM handshake decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_buff_nxt     = r_buff;
        w_iss_nxt      = r_iss_cnt;
        w_cap_nxt      = r_cap_cnt;
        w_out_nxt      = r_out_cnt;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        w_err_nxt      = r_err;
        w_cmd_cnt_nxt  = r_cmd_cnt;
        w_rd_en        = 1'b0;
        w_wr_en        = 1'b0;
        case (r_state)
            S_CMD: begin
                w_rd_en = ~empty & (r_iss_cnt != 4'd8);
                if (w_rd_en) begin
                    w_iss_nxt = r_iss_cnt + 4'd1;
                end else begin
                    w_iss_nxt = r_iss_cnt;
                end
                if (r_rd_pend) begin
                    w_buff_nxt = w_addr;
                    w_cap_nxt  = r_cap_cnt + 3'd1;
                    if (r_cap_cnt == 3'd7) begin
                        w_iss_nxt = 4'd0;
                        if (addr_ok(w_addr)) begin
                            w_state_nxt    = S_MEM;
                            w_mem_req_nxt  = 1'b1;
                            w_mem_addr_nxt = w_addr[63:3] - BASE_WORD;
                        end else begin
                            w_state_nxt = S_RSP;
                            w_buff_nxt  = ERR_DATA;
                            w_err_nxt   = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_CMD;
                    end
                end else begin
                    w_cap_nxt = r_cap_cnt;
                end
            end
            S_MEM: begin
                if (r_mem_req && mem_ack) begin
                    w_buff_nxt    = mem_rdata;
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = S_RSP;
                end else begin
                    w_state_nxt = S_MEM;
                end
            end
            S_RSP: begin
                w_wr_en = ~full;
                if (w_wr_en) begin
                    w_buff_nxt = {8'h00, r_buff[63:8]};
                    w_out_nxt  = r_out_cnt + 3'd1;
                    if (r_out_cnt == 3'd7) begin
                        w_out_nxt     = 3'd0;
                        w_cmd_cnt_nxt = r_cmd_cnt + 16'd1;
                        w_state_nxt   = S_CMD;
                    end else begin
                        w_state_nxt = S_RSP;
                    end
                end else begin
                    w_out_nxt = r_out_cnt;
                end
            end
            default: begin
                w_state_nxt = S_CMD;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_CMD;
            r_buff     <= 64'd0;
            r_iss_cnt  <= 4'd0;
            r_cap_cnt  <= 3'd0;
            r_out_cnt  <= 3'd0;
            r_rd_pend  <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 61'd0;
            r_err      <= 1'b0;
            r_cmd_cnt  <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_buff     <= w_buff_nxt;
            r_iss_cnt  <= w_iss_nxt;
            r_cap_cnt  <= w_cap_nxt;
            r_out_cnt  <= w_out_nxt;
            r_rd_pend  <= w_rd_en;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_err      <= w_err_nxt;
            r_cmd_cnt  <= w_cmd_cnt_nxt;
        end
    end

    // FIFO strobes are combinational, so they are forced quiet while reset is held.
    assign rd_en    = rst_n & w_rd_en;
    assign wr_en    = rst_n & w_wr_en;
    assign din      = (rst_n && (r_state == S_RSP)) ? r_buff[7:0] : 8'h00;
    assign busy     = rst_n & ((r_state != S_CMD) | (r_iss_cnt != 4'd0) |
                               (r_cap_cnt != 3'd0) | r_rd_pend);
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign err      = r_err;
    assign cmd_cnt  = r_cmd_cnt;

endmodule

// File: tb/tb_r_rom_backend.sv
// Directed bench for r_rom_backend: FIFO and ROM models around the DUT, response
// bytes checked against a scoreboard queue filled when each command is queued.
module tb_r_rom_backend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        empty;
    logic        rd_en;
    logic [7:0]  dout = 8'h00;
    logic        full;
    logic        wr_en;
    logic [7:0]  din;
    logic        mem_req;
    logic [60:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata = 64'd0;
    logic        busy;
    logic        err;
    logic [15:0] cmd_cnt;

    localparam logic [63:0] ERR_W = 64'hDEAD_BEEF_DEAD_BEEF;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] cmd_mem [0:255];
    int         cmd_wr = 0;
    int         cmd_rd = 0;
    logic [7:0] exp_q [$];

    int          push_cnt      = 0;
    int          rd_cnt        = 0;
    int          req_pulses    = 0;
    int          req_cycles    = 0;
    int          addr_unstable = 0;
    int          req_cyc       = 0;
    int          ack_dly       = 1;
    logic        req_prev      = 1'b0;
    logic        model_ack     = 1'b0;
    logic        spur_ack      = 1'b0;
    logic [60:0] cap_maddr     = 61'd0;

    always #5 clk = ~clk;

    assign empty   = (cmd_wr == cmd_rd);
    assign mem_ack = model_ack | spur_ack;

    r_rom_backend dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .empty     (empty),
        .rd_en     (rd_en),
        .dout      (dout),
        .full      (full),
        .wr_en     (wr_en),
        .din       (din),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .err       (err),
        .cmd_cnt   (cmd_cnt)
    );

    function automatic logic [63:0] rom_word(input logic [60:0] idx);
        if (idx == 61'd0) return 64'h0807_0605_0403_0201;
        return {16'hC0DE, idx[15:0], ~idx[15:0], 16'h5A17};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Command FIFO: data appears on dout the cycle after the pop.
    always @(posedge clk) begin
        if (rd_en) begin
            dout   <= cmd_mem[cmd_rd % 256];
            cmd_rd <= cmd_rd + 1;
        end
    end

    // Response sink/scoreboard plus ROM model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rd_en) rd_cnt++;
        if (wr_en) begin
            push_cnt++;
            if (exp_q.size() == 0) chk("push_expected_level", 64'(exp_q.size()), 64'd1);
            else chk("din", {56'd0, din}, {56'd0, exp_q.pop_front()});
        end
        if (mem_req) begin
            if (!req_prev) begin
                req_pulses++;
                cap_maddr = mem_addr;
                req_cyc   = 0;
            end else if (mem_addr !== cap_maddr) begin
                addr_unstable++;
            end
            req_cyc++;
            req_cycles++;
            model_ack = (req_cyc >= ack_dly);
            mem_rdata = rom_word(mem_addr);
        end else begin
            model_ack = 1'b0;
            req_cyc   = 0;
        end
        req_prev = mem_req;
    end

    task automatic send_bytes(input logic [63:0] addr, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            cmd_mem[cmd_wr % 256] = addr[i*8 +: 8];
            cmd_wr++;
        end
    endtask

    task automatic expect_word(input logic [63:0] w);
        for (int i = 0; i < 8; i++) exp_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && busy === 1'b0 && cmd_rd == cmd_wr) break;
        end
        chk({tag, "_done_in_time"}, 64'(k < 400), 64'd1);
    endtask

    task automatic wait_pushes(input string tag, input int target);
        int k;
        for (k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (push_cnt >= target) break;
        end
        chk({tag, "_push_wait"}, 64'(k < 400), 64'd1);
    endtask

    task automatic run_cmd(input string tag, input logic [63:0] addr, input logic [63:0] resp,
                           input int exp_req, input logic [60:0] exp_ma);
        int b_rd   = rd_cnt;
        int b_push = push_cnt;
        int b_req  = req_cycles;
        int b_pul  = req_pulses;
        int b_uns  = addr_unstable;
        send_bytes(addr, 0, 7);
        expect_word(resp);
        wait_done(tag);
        chk({tag, "_pops"},       64'(rd_cnt - b_rd),       64'd8);
        chk({tag, "_pushes"},     64'(push_cnt - b_push),   64'd8);
        chk({tag, "_req_cycles"}, 64'(req_cycles - b_req),  64'(exp_req));
        chk({tag, "_req_pulses"}, 64'(req_pulses - b_pul),  64'(exp_req > 0 ? 1 : 0));
        if (exp_req > 0) begin
            chk({tag, "_mem_addr"},      {3'd0, cap_maddr},          {3'd0, exp_ma});
            chk({tag, "_addr_unstable"}, 64'(addr_unstable - b_uns), 64'd0);
        end
    endtask

    initial begin
        int b_push;
        int b_rd;
        int k;
        rst_n = 1'b0;
        full  = 1'b0;
        #2;
        chk("rst_rd_en", {63'd0, rd_en}, 64'd0);
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_din",   {56'd0, din},   64'd0);
        chk("rst_busy",  {63'd0, busy},  64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_err",     {63'd0, err},     64'd0);
        chk("rst_cmd_cnt", {48'd0, cmd_cnt}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", {63'd0, busy}, 64'd0);

        // Stray ack with no request outstanding.
        spur_ack = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        spur_ack = 1'b0;
        chk("spur_busy",    {63'd0, busy},    64'd0);
        chk("spur_mem_req", {63'd0, mem_req}, 64'd0);
        chk("spur_cmd_cnt", {48'd0, cmd_cnt}, 64'd0);

        ack_dly = 3;
        run_cmd("word0", 64'h1000, 64'h0807_0605_0403_0201, 3, 61'd0);
        chk("word0_cmd_cnt", {48'd0, cmd_cnt}, 64'd1);
        chk("word0_err",     {63'd0, err},     64'd0);

        ack_dly = 1;
        run_cmd("last", 64'h2FF8, rom_word(61'h3FF), 1, 61'h3FF);
        chk("last_cmd_cnt", {48'd0, cmd_cnt}, 64'd2);

        run_cmd("oob", 64'h3000, ERR_W, 0, 61'd0);
        chk("oob_err", {63'd0, err}, 64'd1);

        run_cmd("misalign", 64'h1004, ERR_W, 0, 61'd0);
        chk("misalign_err", {63'd0, err}, 64'd1);

        run_cmd("after_err", 64'h1008, rom_word(61'd1), 1, 61'd1);
        chk("after_err_err",     {63'd0, err},     64'd1);
        chk("after_err_cmd_cnt", {48'd0, cmd_cnt}, 64'd5);

        // Back-pressure: full held for 5 cycles after the third byte.
        ack_dly = 2;
        b_push  = push_cnt;
        send_bytes(64'h1010, 0, 7);
        expect_word(rom_word(61'd2));
        wait_pushes("full", b_push + 3);
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_wr_en", {63'd0, wr_en}, 64'd0);
            @(posedge clk); #1;
        end
        full = 1'b0;
        wait_done("full");
        chk("full_pushes", 64'(push_cnt - b_push), 64'd8);
        chk("full_cmd_cnt", {48'd0, cmd_cnt}, 64'd6);

        // Command FIFO runs dry for 4 cycles between bytes 4 and 5.
        b_rd = rd_cnt;
        send_bytes(64'h1018, 0, 3);
        for (k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (cmd_rd == cmd_wr) break;
        end
        chk("gap_drain", 64'(k < 100), 64'd1);
        repeat (4) begin @(posedge clk); #1; end
        chk("gap_paused_pops", 64'(rd_cnt - b_rd), 64'd4);
        send_bytes(64'h1018, 4, 7);
        expect_word(rom_word(61'd3));
        wait_done("gap");
        chk("gap_pops",     64'(rd_cnt - b_rd),    64'd8);
        chk("gap_mem_addr", {3'd0, cap_maddr},     64'd3);
        chk("gap_cmd_cnt",  {48'd0, cmd_cnt},      64'd7);

        // Reset while the ROM read is outstanding.
        ack_dly = 50;
        send_bytes(64'h1020, 0, 7);
        expect_word(rom_word(61'd4));
        for (k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (mem_req === 1'b1) break;
        end
        chk("rstmem_req_seen", 64'(k < 100), 64'd1);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstmem_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rstmem_busy",    {63'd0, busy},    64'd0);
        chk("rstmem_wr_en",   {63'd0, wr_en},   64'd0);
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmem_cmd_cnt", {48'd0, cmd_cnt}, 64'd0);
        chk("rstmem_err",     {63'd0, err},     64'd0);

        // Reset after two response bytes have been pushed.
        ack_dly = 2;
        b_push  = push_cnt;
        send_bytes(64'h1028, 0, 7);
        expect_word(rom_word(61'd5));
        wait_pushes("rstrsp", b_push + 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstrsp_wr_en", {63'd0, wr_en}, 64'd0);
        @(posedge clk); #1;
        chk("rstrsp_busy", {63'd0, busy}, 64'd0);
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstrsp_pushes",  64'(push_cnt - b_push), 64'd2);
        chk("rstrsp_cmd_cnt", {48'd0, cmd_cnt},       64'd0);

        run_cmd("post_rst", 64'h1030, rom_word(61'd6), 2, 61'd6);
        chk("post_rst_cmd_cnt", {48'd0, cmd_cnt}, 64'd1);
        chk("post_rst_err",     {63'd0, err},     64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
